uart_arbiter: RTL and testbench

Round-robin arbiter that shares one `uart_io` instance between `NREQ` requesters, for example a CPU core and a program loader or debug monitor. Read and write channels are arbitrated independently and may run concurrently. Each requester sees the same pulse-request / busy / done-pulse protocol that `uart_io` itself exposes. The block sits between the requesters and `uart_io`, and its downstream ports connect straight to `uart_io`.

---
 rtl/uart_arb_pkg.sv | 27 ++
 rtl/uart_arb_channel.sv | 88 ++++++++
 rtl/uart_arbiter.sv | 86 ++++++++
 tb/tb_uart_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and the round-robin pick helper for the uart_io arbiter.
package uart_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_t;

    localparam int MAX_NREQ = 8;

    // First set bit of pend searching upward from last+1, wrapping at nreq.
    function automatic logic [2:0] rr_pick(input logic [MAX_NREQ-1:0] pend,
                                           input logic [2:0]          last,
                                           input int                  nreq);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= MAX_NREQ; k++) begin
            idx = (int'(last) + k) % nreq;
            if (k <= nreq && !found && pend[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/uart_arb_channel.sv
// One arbitration channel (read or write): pending capture, round-robin grant,
// single-cycle downstream enable and per-requester done pulse.
//
//   state    | meaning
//   ARB_IDLE | no transaction downstream; grant when pend != 0 and io_busy low
//   ARB_WAIT | transaction for 'grant' in flight; leave on io_done
module uart_arb_channel
    import uart_arb_pkg::*;
#(
    parameter int NREQ = 2,
    localparam int IW = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [NREQ-1:0] xen,
    output logic [NREQ-1:0] xbusy,
    output logic [NREQ-1:0] xdone,
    output logic            io_en,
    input  logic            io_busy,
    input  logic            io_done,
    output logic [IW-1:0]   grant,
    output logic            start,
    output logic [IW-1:0]   pick,
    output logic            finish,
    output logic [NREQ-1:0] accept
);

    arb_state_t      state, state_n;
    logic [NREQ-1:0] pend, pend_n, pend_clr, xdone_n;
    logic [IW-1:0]   grant_n, last, last_n;
    logic            io_en_n;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ARB_IDLE;
            pend  <= '0;
            grant <= '0;
            last  <= IW'(NREQ - 1);
            io_en <= 1'b0;
            xdone <= '0;
        end else begin
            state <= state_n;
            pend  <= pend_n;
            grant <= grant_n;
            last  <= last_n;
            io_en <= io_en_n;
            xdone <= xdone_n;
        end
    end

    always_comb begin
        state_n  = state;
        grant_n  = grant;
        last_n   = last;
        io_en_n  = 1'b0;
        xdone_n  = '0;
        pend_clr = '0;
        start    = 1'b0;
        finish   = 1'b0;
        pick     = IW'(rr_pick(MAX_NREQ'(pend), 3'(last), NREQ));
        case (state)
            ARB_IDLE: begin
                if (pend != '0 && !io_busy) begin
                    start   = 1'b1;
                    grant_n = pick;
                    io_en_n = 1'b1;
                    state_n = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (io_done) begin
                    finish          = 1'b1;
                    xdone_n[grant]  = 1'b1;
                    pend_clr[grant] = 1'b1;
                    last_n          = grant;
                    state_n         = ARB_IDLE;
                end
            end
            default: state_n = ARB_IDLE;
        endcase
        // A request landing on the cycle its pend bit clears re-queues it.
        accept = xen & (~pend | pend_clr);
        pend_n = (pend & ~pend_clr) | xen;
    end

    assign xbusy = pend;

endmodule

// File: rtl/uart_arbiter.sv
// Shares one uart_io between NREQ requesters with independent round-robin
// read and write channels; holds per-requester write bytes and the read result.
module uart_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ = 2,
    localparam int IW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req_ren,
    output logic [NREQ-1:0]   req_rbusy,
    output logic [NREQ-1:0]   req_rdone,
    output logic [7:0]        req_rdata,
    input  logic [NREQ-1:0]   req_wen,
    input  logic [8*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]   req_wbusy,
    output logic [NREQ-1:0]   req_wdone,
    output logic              io_ren,
    input  logic [7:0]        io_rdata,
    input  logic              io_rbusy,
    input  logic              io_rdone,
    output logic              io_wen,
    output logic [7:0]        io_wdata,
    input  logic              io_wbusy,
    input  logic              io_wdone,
    output logic [IW-1:0]     rgrant,
    output logic [IW-1:0]     wgrant
);

    logic            r_start, r_finish, w_start, w_finish;
    logic [IW-1:0]   r_pick, w_pick;
    logic [NREQ-1:0] r_accept, w_accept;
    logic [7:0]      wbuf [NREQ];
    logic            unused_sig;

    uart_arb_channel #(.NREQ(NREQ)) u_rd (
        .clk     (clk),
        .rstn    (rstn),
        .xen     (req_ren),
        .xbusy   (req_rbusy),
        .xdone   (req_rdone),
        .io_en   (io_ren),
        .io_busy (io_rbusy),
        .io_done (io_rdone),
        .grant   (rgrant),
        .start   (r_start),
        .pick    (r_pick),
        .finish  (r_finish),
        .accept  (r_accept)
    );

    uart_arb_channel #(.NREQ(NREQ)) u_wr (
        .clk     (clk),
        .rstn    (rstn),
        .xen     (req_wen),
        .xbusy   (req_wbusy),
        .xdone   (req_wdone),
        .io_en   (io_wen),
        .io_busy (io_wbusy),
        .io_done (io_wdone),
        .grant   (wgrant),
        .start   (w_start),
        .pick    (w_pick),
        .finish  (w_finish),
        .accept  (w_accept)
    );

    assign unused_sig = ^{r_start, r_pick, r_accept, w_finish};

    // io_wdata only moves on a new grant, so it stays put through the whole wait.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NREQ; i++) wbuf[i] <= 8'h00;
            io_wdata  <= 8'h00;
            req_rdata <= 8'h00;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_accept[i]) wbuf[i] <= req_wdata[8*i +: 8];
            end
            if (w_start)  io_wdata  <= wbuf[w_pick];
            if (r_finish) req_rdata <= io_rdata;
        end
    end

endmodule

// File: tb/tb_uart_arbiter.sv
// Directed bench for uart_arbiter (NREQ=3) with a transaction-level model
// checked every cycle and hand-computed checks per scenario.
module tb_uart_arbiter;

    localparam int N  = 3;
    localparam int IW = 2;

    logic            clk, rstn;
    logic [N-1:0]    req_ren, req_wen;
    logic [8*N-1:0]  req_wdata;
    logic [N-1:0]    req_rbusy, req_rdone, req_wbusy, req_wdone;
    logic [7:0]      req_rdata, io_rdata, io_wdata;
    logic            io_ren, io_wen, io_rbusy, io_rdone, io_wbusy, io_wdone;
    logic [IW-1:0]   rgrant, wgrant;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    uart_arbiter #(.NREQ(N)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_ren   (req_ren),
        .req_rbusy (req_rbusy),
        .req_rdone (req_rdone),
        .req_rdata (req_rdata),
        .req_wen   (req_wen),
        .req_wdata (req_wdata),
        .req_wbusy (req_wbusy),
        .req_wdone (req_wdone),
        .io_ren    (io_ren),
        .io_rdata  (io_rdata),
        .io_rbusy  (io_rbusy),
        .io_rdone  (io_rdone),
        .io_wen    (io_wen),
        .io_wdata  (io_wdata),
        .io_wbusy  (io_wbusy),
        .io_wdone  (io_wdone),
        .rgrant    (rgrant),
        .wgrant    (wgrant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // uart_io stand-in: done arrives lat cycles after the enable pulse
    int         r_lat = 3, w_lat = 3, rcnt = 0, wcnt = 0;
    logic [7:0] r_byte = 8'h00;

    initial begin
        io_rbusy = 1'b0; io_rdone = 1'b0; io_rdata = 8'hEE;
        io_wbusy = 1'b0; io_wdone = 1'b0;
        forever begin
            tick();
            io_rdone = 1'b0;
            io_wdone = 1'b0;
            io_rdata = 8'hEE;
            if (!rstn) begin
                rcnt = 0; wcnt = 0; io_rbusy = 1'b0; io_wbusy = 1'b0;
            end else begin
                if (rcnt > 0) begin
                    rcnt--;
                    if (rcnt == 0) begin
                        io_rdone = 1'b1; io_rbusy = 1'b0; io_rdata = r_byte;
                    end
                end
                if (io_ren) begin rcnt = r_lat; io_rbusy = 1'b1; end
                if (wcnt > 0) begin
                    wcnt--;
                    if (wcnt == 0) begin io_wdone = 1'b1; io_wbusy = 1'b0; end
                end
                if (io_wen) begin wcnt = w_lat; io_wbusy = 1'b1; end
            end
        end
    end

    // Transaction-level model: owner < 0 means no transaction in flight.
    logic [N-1:0]  m_rpend, m_wpend, m_rdone, m_wdone;
    int            m_rown, m_wown, m_rlast, m_wlast;
    logic          m_ren, m_wen;
    logic [IW-1:0] m_rgrant, m_wgrant;
    logic [7:0]    m_rdata, m_wdata;
    logic [7:0]    m_wbuf [N];

    function automatic int rr_next(input logic [N-1:0] p, input int last);
        for (int k = 1; k <= N; k++) if (p[(last + k) % N]) return (last + k) % N;
        return last;
    endfunction

    initial begin : model
        logic [N-1:0] clr;
        int p;
        forever begin
            @(posedge clk);
            if (!rstn) begin
                m_rpend = '0; m_wpend = '0; m_rdone = '0; m_wdone = '0;
                m_rown = -1; m_wown = -1; m_rlast = N - 1; m_wlast = N - 1;
                m_ren = 1'b0; m_wen = 1'b0; m_rgrant = '0; m_wgrant = '0;
                m_rdata = 8'h00; m_wdata = 8'h00;
                for (int i = 0; i < N; i++) m_wbuf[i] = 8'h00;
            end else begin
                clr = '0; m_ren = 1'b0; m_rdone = '0;
                if (m_rown >= 0) begin
                    if (io_rdone) begin
                        m_rdone[m_rown] = 1'b1; clr[m_rown] = 1'b1;
                        m_rlast = m_rown; m_rdata = io_rdata; m_rown = -1;
                    end
                end else if (m_rpend != '0 && !io_rbusy) begin
                    p = rr_next(m_rpend, m_rlast);
                    m_rown = p; m_rgrant = IW'(p); m_ren = 1'b1;
                end
                m_rpend = (m_rpend & ~clr) | req_ren;

                clr = '0; m_wen = 1'b0; m_wdone = '0;
                if (m_wown >= 0) begin
                    if (io_wdone) begin
                        m_wdone[m_wown] = 1'b1; clr[m_wown] = 1'b1;
                        m_wlast = m_wown; m_wown = -1;
                    end
                end else if (m_wpend != '0 && !io_wbusy) begin
                    p = rr_next(m_wpend, m_wlast);
                    m_wown = p; m_wgrant = IW'(p); m_wen = 1'b1; m_wdata = m_wbuf[p];
                end
                for (int i = 0; i < N; i++)
                    if (req_wen[i] && (!m_wpend[i] || clr[i])) m_wbuf[i] = req_wdata[8*i +: 8];
                m_wpend = (m_wpend & ~clr) | req_wen;
            end
        end
    end

    int n_ren = 0, n_wen = 0;
    int n_rdone [N];
    int n_wdone [N];

    initial begin
        for (int i = 0; i < N; i++) begin n_rdone[i] = 0; n_wdone[i] = 0; end
        forever begin
            @(negedge clk);
            chk("io_ren",    io_ren,    m_ren);
            chk("io_wen",    io_wen,    m_wen);
            chk("io_wdata",  io_wdata,  m_wdata);
            chk("req_rbusy", req_rbusy, m_rpend);
            chk("req_wbusy", req_wbusy, m_wpend);
            chk("req_rdone", req_rdone, m_rdone);
            chk("req_wdone", req_wdone, m_wdone);
            chk("req_rdata", req_rdata, m_rdata);
            chk("rgrant",    rgrant,    m_rgrant);
            chk("wgrant",    wgrant,    m_wgrant);
            if (io_ren) n_ren++;
            if (io_wen) n_wen++;
            for (int i = 0; i < N; i++) begin
                if (req_rdone[i] === 1'b1) n_rdone[i]++;
                if (req_wdone[i] === 1'b1) n_wdone[i]++;
            end
        end
    end

    task automatic rst_pulse();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if ({req_rbusy, req_wbusy, io_rbusy, io_wbusy} == '0) break;
            tick();
        end
        chk("drain_busy", {req_rbusy, req_wbusy}, 0);
        tick();
    endtask

    initial begin
        int c, extra, b0, b1, b2, rc, wc;
        int ord[$];
        logic [7:0] caps[$];
        logic [7:0] held;
        logic [7:0] exp_seq [6];

        rstn = 1'b0; req_ren = '0; req_wen = '0; req_wdata = '0;
        repeat (3) tick();
        chk("rst_io_ren", io_ren, 0);
        chk("rst_io_wen", io_wen, 0);
        chk("rst_io_wdata", io_wdata, 0);
        chk("rst_busy", {req_rbusy, req_wbusy}, 0);
        chk("rst_done", {req_rdone, req_wdone}, 0);
        chk("rst_rdata", req_rdata, 0);
        chk("rst_grants", {rgrant, wgrant}, 0);
        rstn = 1'b1;
        tick();

        // single read from requester 1, io_rdone 6 cycles after io_ren
        r_lat = 6; r_byte = 8'h5A;
        req_ren = 3'b010;
        tick(); req_ren = '0;
        chk("t1_rbusy_c1", req_rbusy[1], 1);
        chk("t1_ren_c1", io_ren, 0);
        tick();
        chk("t1_ren_c2", io_ren, 1);
        c = 2; extra = 0;
        for (int i = 0; i < 20; i++) begin
            tick(); c++;
            if (io_ren) extra++;
            if (req_rdone[1]) break;
        end
        chk("t1_done_cycle", c, 9);
        chk("t1_rdata", req_rdata, 8'h5A);
        chk("t1_rbusy_done", req_rbusy[1], 0);
        chk("t1_extra_ren", extra, 0);
        drain();

        // simultaneous reads right after reset: 0 then 1
        rst_pulse();
        r_lat = 3; r_byte = 8'h3C;
        b0 = n_ren; b1 = n_rdone[0]; b2 = n_rdone[1];
        req_ren = 3'b011;
        for (int i = 0; i < 40; i++) begin
            tick(); req_ren = '0;
            if (req_rdone[0]) ord.push_back(0);
            if (req_rdone[1]) ord.push_back(1);
        end
        chk("t2_done_total", ord.size(), 2);
        chk("t2_first", ord.size() > 0 ? ord[0] : 99, 0);
        chk("t2_second", ord.size() > 1 ? ord[1] : 99, 1);
        chk("t2_ren_pulses", n_ren - b0, 2);
        chk("t2_rdone0_once", n_rdone[0] - b1, 1);
        chk("t2_rdone1_once", n_rdone[1] - b2, 1);

        // write fairness: everyone re-requests on its done
        w_lat = 2;
        exp_seq = '{8'h10, 8'h20, 8'h30, 8'h10, 8'h20, 8'h30};
        req_wdata = {8'h30, 8'h20, 8'h10};
        req_wen = 3'b111;
        held = 8'h00;
        for (int i = 0; i < 80; i++) begin
            tick();
            req_wen = (caps.size() < 6) ? req_wdone : '0;
            if (io_wen) begin caps.push_back(io_wdata); held = io_wdata; end
            if (req_wdone != '0) chk("t3_wdata_hold", io_wdata, held);
            if (caps.size() >= 6 && req_wbusy == '0 && !io_wbusy) break;
        end
        req_wen = '0;
        chk("t3_grants", caps.size() >= 6, 1);
        for (int i = 0; i < 6; i++)
            chk($sformatf("t3_seq%0d", i), i < caps.size() ? caps[i] : 8'hFF, exp_seq[i]);
        drain();

        // duplicate write request while pending
        w_lat = 4;
        b0 = n_wen; b1 = n_wdone[0];
        req_wdata = {8'h00, 8'h00, 8'hAA};
        req_wen = 3'b001;
        tick();
        req_wdata = {8'h00, 8'h00, 8'hBB};
        tick(); req_wen = '0;
        chk("t4_wen_c2", io_wen, 1);
        chk("t4_wdata", io_wdata, 8'hAA);
        repeat (20) tick();
        chk("t4_wen_once", n_wen - b0, 1);
        chk("t4_wdone_once", n_wdone[0] - b1, 1);
        chk("t4_wdata_kept", io_wdata, 8'hAA);
        drain();

        // concurrent read (req 0) and write (req 1)
        r_lat = 5; w_lat = 3; r_byte = 8'h81;
        req_ren = 3'b001; req_wen = 3'b010; req_wdata = {8'h00, 8'h77, 8'h00};
        tick(); req_ren = '0; req_wen = '0;
        tick();
        chk("t5_ren_c2", io_ren, 1);
        chk("t5_wen_c2", io_wen, 1);
        chk("t5_wdata", io_wdata, 8'h77);
        c = 2; rc = -1; wc = -1;
        for (int i = 0; i < 20; i++) begin
            tick(); c++;
            if (req_rdone[0]) rc = c;
            if (req_wdone[1]) wc = c;
        end
        chk("t5_wdone_cycle", wc, 6);
        chk("t5_rdone_cycle", rc, 8);
        chk("t5_rdata", req_rdata, 8'h81);
        drain();

        // reset during ARB_WAIT abandons the read
        r_lat = 10; r_byte = 8'h99;
        req_ren = 3'b100;
        tick(); req_ren = '0;
        tick();
        chk("t6_ren_c2", io_ren, 1);
        tick(); tick();
        b0 = n_rdone[2];
        rstn = 1'b0;
        tick();
        chk("t6_rst_busy", {req_rbusy, req_wbusy}, 0);
        chk("t6_rst_grant", rgrant, 0);
        chk("t6_rst_en", {io_ren, io_wen}, 0);
        chk("t6_rst_rdata", req_rdata, 0);
        tick();
        rstn = 1'b1;
        repeat (15) tick();
        chk("t6_no_done", n_rdone[2] - b0, 0);
        r_lat = 2; r_byte = 8'hC3;
        req_ren = 3'b100;
        c = 0;
        for (int i = 0; i < 20; i++) begin
            tick(); c++; req_ren = '0;
            if (req_rdone[2]) break;
        end
        chk("t6_fresh_cycle", c, 5);
        chk("t6_fresh_rdata", req_rdata, 8'hC3);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
